// File: rtl/rate_limiter.sv
// rate_limiter: per-customer token-bucket rate limiter for the scheduler dequeue path.
//
// The scheduler presents the head queue ID. One clock later the block answers whether the
// dequeue is allowed, together with the base queue ID of the next customer to try. Dequeued
// packet lengths are charged against the bucket of the customer that was checked last.
// A background pointer sweeps all buckets, one per clock, adding RATE and clamping to BURST.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-low reset
//   wb_cyc_i/adr/we/dat   Wishbone slave: adr[16:2] entry, adr[1:0] 0=RATE 1=BURST 2=TOKENS 3=EN
//   wb_ack_o, wb_dat_o    1-cycle ack one clock after cyc; registered read data valid with ack
//   id_i, id_valid_i      queue ID to check, 1-cycle request strobe
//   ok_o, ok_valid_o      dequeue allowed, 1-cycle response strobe
//   next_id_o             base queue ID of the following customer (wraps to 0)
//   drop_it_i             scheduler declined the packet, no charge
//   take_it_i             packet dequeued, charge update_plen_i to the latched customer
//   update_plen_i         packet length in bytes, sampled with take_it_i
module rate_limiter #(
  parameter int WB_DATA_WIDTH     = 32,
  parameter int QUEUE_ID_WIDTH    = 12,
  parameter int NUM_ENTRIES       = 64,
  parameter int PACKET_SIZE_WIDTH = 16,
  parameter int QUEUE_ID_OFFSET   = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wb_cyc_i,
  input  logic [16:0]                  wb_adr_i,
  input  logic                         wb_we_i,
  input  logic [WB_DATA_WIDTH-1:0]     wb_dat_i,
  output logic                         wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0]     wb_dat_o,
  input  logic [QUEUE_ID_WIDTH-1:0]    id_i,
  input  logic                         id_valid_i,
  output logic                         ok_o,
  output logic                         ok_valid_o,
  output logic [QUEUE_ID_WIDTH-1:0]    next_id_o,
  input  logic                         drop_it_i,
  input  logic                         take_it_i,
  input  logic [PACKET_SIZE_WIDTH-1:0] update_plen_i
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int SH_W  = IDX_W + QUEUE_ID_OFFSET;

  // Most negative 33-bit token count; deficits saturate here instead of wrapping positive.
  localparam logic signed [34:0] TOK_MIN = -35'sd4294967296;

  // Bucket state
  logic        [31:0] rate   [NUM_ENTRIES];
  logic        [31:0] burst  [NUM_ENTRIES];
  logic signed [32:0] tokens [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] en;

  logic [IDX_W-1:0] ptr;    // refill sweep pointer
  logic [IDX_W-1:0] cust;   // customer of the most recent check, target of charges

  // Wishbone decode
  logic                     wb_stb;
  logic                     entry_ok;
  logic [IDX_W-1:0]         wb_idx;
  logic [1:0]               wb_sel;
  logic [WB_DATA_WIDTH:0]   dat_sx;
  logic signed [32:0]       tok_wdata;
  logic [32:0]              tok_rd;
  logic                     wr_any;
  logic                     wr_rate;
  logic                     wr_burst;
  logic                     wr_tok;
  logic                     wr_en;
  logic [WB_DATA_WIDTH-1:0] rd_word;

  // Check path
  logic [IDX_W-1:0]          cust_in;
  logic [IDX_W-1:0]          cust_nxt;
  logic [QUEUE_ID_WIDTH-1:0] next_id_calc;
  logic                      ok_calc;

  // Bucket update path
  logic               charge_req;
  logic               refill_req;
  logic               same_entry;
  logic               refill_do;
  logic               charge_do;
  logic signed [34:0] plen_s;
  logic signed [34:0] burst_s;
  logic signed [34:0] refill_sum;
  logic signed [32:0] refill_val;
  logic signed [32:0] charge_val;

  function automatic logic signed [34:0] sext35(input logic signed [32:0] v);
    return {{2{v[32]}}, v};
  endfunction

  function automatic logic signed [32:0] sat_low(input logic signed [34:0] v);
    if (v < TOK_MIN) return TOK_MIN[32:0];
    return v[32:0];
  endfunction

  always_comb begin
    wb_stb   = wb_cyc_i & ~wb_ack_o;
    entry_ok = (wb_adr_i[16:2] < 15'(NUM_ENTRIES));
    wb_idx   = IDX_W'(wb_adr_i[16:2]);
    wb_sel   = wb_adr_i[1:0];
    // A 32-bit bus sign-extends a TOKENS write; wider buses carry all 33 bits.
    dat_sx    = {wb_dat_i[WB_DATA_WIDTH-1], wb_dat_i};
    tok_wdata = $signed(33'(dat_sx));
    wr_any    = wb_stb & wb_we_i & entry_ok;
    wr_rate   = wr_any & (wb_sel == 2'd0);
    wr_burst  = wr_any & (wb_sel == 2'd1);
    wr_tok    = wr_any & (wb_sel == 2'd2);
    wr_en     = wr_any & (wb_sel == 2'd3);
  end

  always_comb begin
    rd_word = '0;
    tok_rd  = tokens[wb_idx];
    if (entry_ok) begin
      case (wb_sel)
        2'd0:    rd_word = WB_DATA_WIDTH'(rate[wb_idx]);
        2'd1:    rd_word = WB_DATA_WIDTH'(burst[wb_idx]);
        2'd2:    rd_word = WB_DATA_WIDTH'(tok_rd);
        default: rd_word = WB_DATA_WIDTH'(en[wb_idx]);
      endcase
    end
  end

  always_comb begin
    cust_in      = IDX_W'(id_i >> QUEUE_ID_OFFSET);
    cust_nxt     = cust_in + 1'b1;
    next_id_calc = QUEUE_ID_WIDTH'(SH_W'(cust_nxt) << QUEUE_ID_OFFSET);
    ok_calc      = ~en[cust_in] | ~tokens[cust_in][32];
  end

  // Refill and charge on the same entry fold into one sum before the BURST clamp;
  // otherwise each updates its own entry independently.
  always_comb begin
    // Decline takes precedence if the scheduler raises both strobes.
    charge_req = take_it_i & ~drop_it_i & en[cust];
    refill_req = en[ptr];
    same_entry = (cust == ptr);
    plen_s     = $signed(35'(update_plen_i));
    burst_s    = $signed({3'b000, burst[ptr]});
    refill_sum = sext35(tokens[ptr]) + $signed({3'b000, rate[ptr]});
    if (charge_req && same_entry) refill_sum = refill_sum - plen_s;
    if (refill_sum > burst_s) refill_sum = burst_s;
    refill_val = sat_low(refill_sum);
    charge_val = sat_low(sext35(tokens[cust]) - plen_s);
    refill_do  = refill_req;
    charge_do  = charge_req & ~(refill_req & same_entry);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        rate[i]   <= '0;
        burst[i]  <= '0;
        tokens[i] <= '0;
      end
      en         <= '0;
      ptr        <= '0;
      cust       <= '0;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      ok_o       <= 1'b0;
      ok_valid_o <= 1'b0;
      next_id_o  <= '0;
    end else begin
      wb_ack_o <= wb_stb;
      if (wb_stb) wb_dat_o <= rd_word;

      if (wr_rate)  rate[wb_idx]  <= wb_dat_i[31:0];
      if (wr_burst) burst[wb_idx] <= wb_dat_i[31:0];
      if (wr_en)    en[wb_idx]    <= wb_dat_i[0];

      ptr <= ptr + 1'b1;
      // Later assignments win: a TOKENS write overrides refill and charge.
      if (refill_do) tokens[ptr]    <= refill_val;
      if (charge_do) tokens[cust]   <= charge_val;
      if (wr_tok)    tokens[wb_idx] <= tok_wdata;

      ok_valid_o <= id_valid_i;
      if (id_valid_i) begin
        cust      <= cust_in;
        ok_o      <= ok_calc;
        next_id_o <= next_id_calc;
      end
    end
  end

endmodule

// File: tb/tb_rate_limiter.sv
module tb_rate_limiter;

  bit          clk;
  logic        rst;
  logic        wb_cyc;
  logic [16:0] wb_adr;
  logic        wb_we;
  logic [63:0] wb_wdat;
  logic        wb_ack;
  logic [63:0] wb_rdat;
  logic [11:0] id;
  logic        id_valid;
  logic        ok;
  logic        ok_valid;
  logic [11:0] next_id;
  logic        drop_it;
  logic        take_it;
  logic [15:0] plen;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] id;
    logic        en;
    logic [32:0] tok;
    logic        exp_ok;
  } vec_t;

  typedef struct {
    logic        ok;
    logic [11:0] next_id;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  logic [5:0] tb_ptr;

  rate_limiter #(.WB_DATA_WIDTH(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(wb_cyc), .wb_adr_i(wb_adr), .wb_we_i(wb_we), .wb_dat_i(wb_wdat),
    .wb_ack_o(wb_ack), .wb_dat_o(wb_rdat),
    .id_i(id), .id_valid_i(id_valid), .ok_o(ok), .ok_valid_o(ok_valid), .next_id_o(next_id),
    .drop_it_i(drop_it), .take_it_i(take_it), .update_plen_i(plen)
  );

  always #5 clk = ~clk;

  // Refill pointer position: the entry refilled on the next rising edge.
  always @(posedge clk) begin
    if (!rst) tb_ptr <= '0;
    else      tb_ptr <= tb_ptr + 6'd1;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (ok_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response: ok_valid=1 with no request pending (expected 0)");
      end else begin
        e = sb.pop_front();
        chk("resp_ok", 64'(ok), 64'(e.ok));
        chk("resp_next_id", 64'(next_id), 64'(e.next_id));
      end
    end
  end

  task automatic wb_cycle(input logic we, input int unsigned idx, input logic [1:0] sel,
                          input logic [63:0] wdat, output logic [63:0] rdat);
    wb_cyc  = 1'b1;
    wb_we   = we;
    wb_adr  = {15'(idx), sel};
    wb_wdat = wdat;
    @(posedge clk);
    #1;
    chk("wb_ack_latency", 64'(wb_ack), 64'd1);
    rdat = wb_rdat;
    @(negedge clk);
    wb_cyc = 1'b0;
    wb_we  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_write(input int unsigned idx, input logic [1:0] sel, input logic [63:0] d);
    logic [63:0] unused_r;
    wb_cycle(1'b1, idx, sel, d, unused_r);
  endtask

  task automatic wb_read(input string name, input int unsigned idx, input logic [1:0] sel,
                         input logic [63:0] exp);
    logic [63:0] r;
    wb_cycle(1'b0, idx, sel, 64'd0, r);
    chk(name, r, exp);
  endtask

  task automatic push_exp(input logic [11:0] qid, input logic exp_ok);
    exp_t e;
    int unsigned c;
    c = ((int'(qid) >> 3) + 1) % 64;
    e.ok      = exp_ok;
    e.next_id = 12'(c << 3);
    sb.push_back(e);
  endtask

  // Called at a falling edge; the response is scored at the next falling edge.
  task automatic check_id(input logic [11:0] qid, input logic exp_ok);
    push_exp(qid, exp_ok);
    id       = qid;
    id_valid = 1'b1;
    @(negedge clk);
    id_valid = 1'b0;
  endtask

  task automatic pulse_take(input logic [15:0] len);
    take_it = 1'b1;
    plen    = len;
    @(negedge clk);
    take_it = 1'b0;
  endtask

  task automatic wait_ptr(input logic [5:0] target);
    int n = 0;
    while (tb_ptr != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tb_ptr != target) begin
      errors++;
      $display("FAIL ptr_sync: pointer 0x%0h, required 0x%0h", tb_ptr, target);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] acks;
    vecs[0] = '{12'h010, 1'b1, 33'd100,          1'b1};
    vecs[1] = '{12'h01F, 1'b1, 33'h1_FFFF_FFFF,  1'b0};
    vecs[2] = '{12'h1F8, 1'b1, 33'h1_FFFF_FFFF,  1'b0};
    vecs[3] = '{12'h3FF, 1'b1, 33'd0,            1'b1};
    vecs[4] = '{12'h208, 1'b0, 33'h1_FFFF_FE0C,  1'b1};
    vecs[5] = '{12'hFFF, 1'b1, 33'h0_FFFF_FFFF,  1'b1};
    vecs[6] = '{12'h800, 1'b1, 33'h1_0000_0000,  1'b0};
    vecs[7] = '{12'h028, 1'b1, 33'd0,            1'b1};

    rst = 1'b0; wb_cyc = 1'b0; wb_adr = '0; wb_we = 1'b0; wb_wdat = '0;
    id = '0; id_valid = 1'b0; drop_it = 1'b0; take_it = 1'b0; plen = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    chk("rst_wb_ack", 64'(wb_ack), 64'd0);
    chk("rst_wb_dat", wb_rdat, 64'd0);
    chk("rst_ok", 64'(ok), 64'd0);
    chk("rst_ok_valid", 64'(ok_valid), 64'd0);
    chk("rst_next_id", 64'(next_id), 64'd0);

    // Disabled bucket always passes
    check_id(12'h013, 1'b1);

    for (int i = 0; i < 8; i++) begin
      int unsigned e;
      e = (int'(vecs[i].id) >> 3) % 64;
      wb_write(e, 2'd3, 64'(vecs[i].en));
      wb_write(e, 2'd2, 64'(vecs[i].tok));
      check_id(vecs[i].id, vecs[i].exp_ok);
    end

    // Charge into deficit
    wb_write(2, 2'd1, 64'd1000);
    wb_write(2, 2'd0, 64'd0);
    wb_write(2, 2'd3, 64'd1);
    wb_write(2, 2'd2, 64'd100);
    check_id(12'h010, 1'b1);
    pulse_take(16'd150);
    check_id(12'h010, 1'b0);
    wb_read("tokens_deficit", 2, 2'd2, 64'h1_FFFF_FFCE);

    // Charge lands on previously latched customer while a new check arrives
    push_exp(12'h018, 1'b0);
    id = 12'h018; id_valid = 1'b1; take_it = 1'b1; plen = 16'd10;
    @(negedge clk);
    id_valid = 1'b0; take_it = 1'b0;
    wb_read("tokens_charge_old_cust", 2, 2'd2, 64'h1_FFFF_FFC4);
    wb_read("tokens_other_cust", 3, 2'd2, 64'h1_FFFF_FFFF);

    check_id(12'h010, 1'b0);
    drop_it = 1'b1;
    @(negedge clk);
    drop_it = 1'b0;
    wb_read("tokens_after_drop", 2, 2'd2, 64'h1_FFFF_FFC4);

    // Exactly five refills of 10 over 320 clocks
    wb_write(2, 2'd2, 64'h1_FFFF_FFCE);
    wb_write(2, 2'd0, 64'd10);
    repeat (318) @(negedge clk);
    wb_write(2, 2'd0, 64'd0);
    wb_read("tokens_five_sweeps", 2, 2'd2, 64'd0);
    check_id(12'h010, 1'b1);
    wb_write(2, 2'd0, 64'd10);
    repeat (7040) @(negedge clk);
    wb_read("tokens_saturate", 2, 2'd2, 64'd1000);

    // TOKENS write coinciding with refill and charge of the same entry
    check_id(12'h010, 1'b1);
    wait_ptr(6'd2);
    wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = {15'd2, 2'd2}; wb_wdat = 64'd777;
    take_it = 1'b1; plen = 16'd40;
    @(posedge clk);
    #1;
    chk("wb_ack_latency", 64'(wb_ack), 64'd1);
    @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0; take_it = 1'b0;
    @(negedge clk);
    wb_read("tokens_write_wins", 2, 2'd2, 64'd777);

    // Refill and charge combined: 777 + 10 - 40
    wait_ptr(6'd2);
    pulse_take(16'd40);
    wb_read("tokens_refill_plus_charge", 2, 2'd2, 64'd747);

    // Register access at both ends of the table and past it
    wb_write(0, 2'd0, 64'h1234_5678);
    wb_write(0, 2'd1, 64'hCAFE_F00D);
    wb_write(0, 2'd3, 64'd1);
    wb_write(63, 2'd0, 64'hAAAA_AAAA_FFFF_FFFF);
    wb_write(63, 2'd1, 64'd1);
    wb_write(63, 2'd3, 64'hFFFF_FFFF);
    wb_read("rate_e0", 0, 2'd0, 64'h1234_5678);
    wb_read("burst_e0", 0, 2'd1, 64'hCAFE_F00D);
    wb_read("en_e0", 0, 2'd3, 64'd1);
    wb_read("rate_e63", 63, 2'd0, 64'hFFFF_FFFF);
    wb_read("burst_e63", 63, 2'd1, 64'd1);
    wb_read("en_e63", 63, 2'd3, 64'd1);
    wb_write(64, 2'd0, 64'hDEAD);
    wb_read("rate_e64", 64, 2'd0, 64'd0);
    wb_read("en_e64", 64, 2'd3, 64'd0);
    wb_read("rate_e0_no_alias", 0, 2'd0, 64'h1234_5678);

    // Held cyc: ack alternates
    wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = {15'd0, 2'd0};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      acks[i] = wb_ack;
    end
    chk("ack_pattern", 64'(acks), 64'b101);
    @(negedge clk);
    wb_cyc = 1'b0;
    @(negedge clk);

    // Reset with a response pending
    id = 12'h1F8; id_valid = 1'b1; rst = 1'b0;
    @(negedge clk);
    id_valid = 1'b0; rst = 1'b1;
    chk("midrst_ok_valid", 64'(ok_valid), 64'd0);
    chk("midrst_ok", 64'(ok), 64'd0);
    chk("midrst_next_id", 64'(next_id), 64'd0);
    chk("midrst_wb_dat", wb_rdat, 64'd0);
    @(negedge clk);
    chk("midrst_no_late_resp", 64'(ok_valid), 64'd0);
    wb_read("midrst_tokens", 2, 2'd2, 64'd0);
    wb_read("midrst_en", 2, 2'd3, 64'd0);
    wb_read("midrst_rate", 0, 2'd0, 64'd0);
    check_id(12'h010, 1'b1);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_responses: %0d outstanding, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
